// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display feeder path.
//   state_t        : conversion FSM states
//   BCD_MAX        : largest value representable in four BCD digits
//   DIGITS         : number of BCD digits held for the scanner
//   POS_*          : scanner nibble-MSB indices for each digit
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned BCD_MAX = 9999;
  localparam int unsigned DIGITS  = 4;

  localparam logic [3:0] POS_UNITS     = 4'd3;
  localparam logic [3:0] POS_TENS      = 4'd7;
  localparam logic [3:0] POS_HUNDREDS  = 4'd11;
  localparam logic [3:0] POS_THOUSANDS = 4'd15;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell for one BCD nibble.
//   d : nibble before the shift
//   q : d + 3 when d >= 5, otherwise d (no carry out of the nibble)
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) begin
      q = d + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_display_feeder.sv
// Binary-to-BCD feeder for the 4-digit seven-segment scanner.
// A sequential double-dabble converts a saturated binary value into four
// packed BCD digits; the result is published to a display register only when
// the conversion completes, so the scanner never sees a partial value.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   value     : binary input, sampled when start is accepted
//   start     : conversion request (pulse or level), ignored while busy
//   busy      : conversion in progress, through the DONE cycle
//   done      : one-cycle pulse when the display register has new digits
//   overflow  : last accepted value exceeded 9999 (saturated)
//   posicion  : scanner nibble MSB index (3/7/11/15), low two bits ignored
//   numA      : BCD digit selected by posicion, combinational
module bcd_display_feeder
  import display_pkg::*;
#(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  input  logic [3:0]       posicion,
  output logic [3:0]       numA
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned BW = 4 * DIGITS;

  state_t           state;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    acc_adj;
  logic [BW-1:0]    acc_next;
  logic [BW-1:0]    display;
  logic [WIDTH-1:0] bin;
  logic [CW-1:0]    cnt;
  logic             over;
  logic [3:0]       base;

  assign over = (32'(value) > BCD_MAX);

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d (acc[4*i +: 4]),
      .q (acc_adj[4*i +: 4])
    );
  end

  assign acc_next = {acc_adj[BW-2:0], bin[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      acc      <= '0;
      bin      <= '0;
      cnt      <= '0;
      display  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bin      <= over ? WIDTH'(BCD_MAX) : value;
            overflow <= over;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc_next;
          bin <= {bin[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          // The final accumulator is loaded into the display on the last
          // shift edge so that done and the new digits share the DONE cycle.
          if (cnt == CW'(WIDTH - 1)) begin
            display <= acc_next;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Masking keeps only posicion[3:2]; the nibble base is a multiple of 4.
  assign base = posicion & 4'b1100;
  assign numA = display[base +: 4];

endmodule

// File: tb/tb_bcd_display_feeder.sv
module tb_bcd_display_feeder;
  import display_pkg::*;

  localparam int unsigned WIDTH = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] value;
  logic             start;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [3:0]       posicion;
  logic [3:0]       numA;

  int unsigned n_pass   = 0;
  int unsigned n_total  = 0;
  int unsigned done_cnt = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_disp = '0;
  bit          chk_en   = 1'b0;

  bcd_display_feeder #(.WIDTH(WIDTH), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .posicion (posicion),
    .numA     (numA)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [15:0] bcd_of(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Free-running scanner, including positions with nonzero low bits.
  logic [3:0] pos_seq [12];
  int         pidx = 0;
  initial begin
    pos_seq = '{POS_UNITS, POS_TENS, POS_HUNDREDS, POS_THOUSANDS,
                4'd0, 4'd4, 4'd8, 4'd12, 4'd2, 4'd6, 4'd10, 4'd14};
    posicion = POS_UNITS;
    forever begin
      @(posedge clk);
      #2;
      pidx = (pidx + 1) % 12;
      posicion = pos_seq[pidx];
    end
  end

  // Reset clears the expected display and drops any pending conversion.
  always @(posedge clk) begin
    if (rst) begin
      exp_disp = '0;
      sb.delete();
    end
  end

  // Every cycle: consume a scoreboard entry on done, compare the read port.
  always @(negedge clk) begin
    if (chk_en) begin
      int idx;
      if (done) begin
        done_cnt++;
        check("done_without_pending", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) exp_disp = sb.pop_front();
      end
      idx = int'(posicion) / 4;
      check($sformatf("numA_pos%0d", posicion), numA, exp_disp[idx*4 +: 4]);
    end
  end

  // Starts a conversion when idle; p1/p2 are edge offsets (1..15) at which a
  // spurious start is presented while the block is busy.
  task automatic convert(input int v, input int p1, input int p2);
    int unsigned n0;
    n0    = done_cnt;
    value = WIDTH'(v);
    start = 1'b1;
    tick();
    sb.push_back(bcd_of(v));
    start = 1'b0;
    value = WIDTH'($urandom);
    check("busy_after_start", busy, 1);
    check("ovf_latched", overflow, 32'(v > 9999));
    for (int k = 1; k <= 14; k++) begin
      start = (k == p1 || k == p2);
      if (start) value = WIDTH'($urandom);
      tick();
      if (k == 14) check("done_at_latency", done, 1);
      else         check("done_early", done, 0);
      check("busy_during", busy, 1);
    end
    start = (p1 == 15 || p2 == 15);
    tick();
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_clear", busy, 0);
    check("done_count", done_cnt - n0, 1);
  endtask

  initial begin
    int unsigned n0;
    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    repeat (4) tick();
    rst = 1'b0;
    repeat (4) tick();

    convert(1234, 0, 0);
    convert(0, 0, 0);
    convert(9999, 0, 0);
    convert(16383, 0, 0);
    check("sat_ovf_held", overflow, 1);
    convert(42, 0, 0);

    convert(1234, 0, 0);
    convert(5678, 5, 15);
    repeat (20) tick();
    check("no_requeued_start", busy, 0);

    // Reset in the middle of a conversion.
    n0    = done_cnt;
    value = WIDTH'(777);
    start = 1'b1;
    tick();
    sb.push_back(bcd_of(777));
    start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ovf", overflow, 0);
    rst = 1'b0;
    repeat (20) tick();
    check("abort_no_done", done_cnt - n0, 0);
    convert(777, 0, 0);

    // Start held high: re-accepted on the first IDLE cycle after DONE.
    n0    = done_cnt;
    value = WIDTH'(321);
    start = 1'b1;
    tick();
    sb.push_back(bcd_of(321));
    repeat (14) tick();
    check("lvl_done1", done, 1);
    tick();
    check("lvl_gap_busy", busy, 0);
    tick();
    sb.push_back(bcd_of(321));
    start = 1'b0;
    check("lvl_reaccept_busy", busy, 1);
    for (int i = 0; i < 30 && done_cnt - n0 < 2; i++) tick();
    check("lvl_done_count", done_cnt - n0, 2);

    repeat (8) tick();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
